ecc_apb_sequencer: RTL and testbench

Job-level controller that sequences the ECC_ENC_DEC block through its APB slave port. Accepts one encode/decode/full-channel job per request handshake, issues the NOISE, CODEWORD_WIDTH, DATA_IN and CTRL register writes as APB master, then waits for operation_done. Captures data_out and num_of_errors into a held response. Sits between the system-side job source and ECC_ENC_DEC, replacing hand-driven APB traffic.

---
 rtl/ecc_seq_pkg.sv | 40 ++++
 rtl/ecc_apb_write_master.sv | 48 ++++
 rtl/ecc_apb_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_ecc_apb_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_seq_pkg.sv
// Shared definitions for the ECC_ENC_DEC job sequencer:
// register offsets, op/width codes, FSM state type and write-slot helper.
package ecc_seq_pkg;

    localparam logic [3:0] REG_CTRL     = 4'h0;
    localparam logic [3:0] REG_DATA_IN  = 4'h4;
    localparam logic [3:0] REG_CW_WIDTH = 4'h8;
    localparam logic [3:0] REG_NOISE    = 4'hC;

    localparam logic [1:0] OP_ENC = 2'd0;
    localparam logic [1:0] OP_DEC = 2'd1;
    localparam logic [1:0] OP_FC  = 2'd2;
    localparam logic [1:0] OP_RSV = 2'd3;

    localparam logic [1:0] CW_8  = 2'd0;
    localparam logic [1:0] CW_16 = 2'd1;
    localparam logic [1:0] CW_32 = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_WAIT,
        S_RESP
    } state_t;

    // Write slot -> register offset; slot 3 (CTRL) is always issued last.
    function automatic logic [3:0] reg_of(input logic [1:0] idx);
        logic [3:0] r;
        r = REG_CTRL;
        unique case (idx)
            2'd0: r = REG_NOISE;
            2'd1: r = REG_CW_WIDTH;
            2'd2: r = REG_DATA_IN;
            2'd3: r = REG_CTRL;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ecc_apb_write_master.sv
// Two-phase APB write engine (SETUP then ACCESS, no PREADY).
// Ports: clk, rst (sync, active low), start/addr/wdata in; APB master
// signals out plus done, high during the ACCESS cycle. A start in the
// ACCESS cycle chains straight into the next SETUP.
module ecc_apb_write_master #(
    parameter int AW = 20,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          psel,
    output logic          penable,
    output logic          pwrite,
    output logic [AW-1:0] paddr,
    output logic [DW-1:0] pwdata,
    output logic          done
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            paddr   <= '0;
            pwdata  <= '0;
            done    <= 1'b0;
        end else if (start) begin
            psel    <= 1'b1;
            penable <= 1'b0;
            pwrite  <= 1'b1;
            paddr   <= addr;
            pwdata  <= wdata;
            done    <= 1'b0;
        end else if (psel && !penable) begin
            penable <= 1'b1;
            done    <= 1'b1;
        end else begin
            psel    <= 1'b0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            done    <= 1'b0;
        end
    end

endmodule

// File: rtl/ecc_apb_sequencer.sv
// Job sequencer for ECC_ENC_DEC: writes NOISE, CODEWORD_WIDTH, DATA_IN, CTRL
// over APB, waits for operation_done (with timeout) and holds a response.
// Ports: req_* job request, APB master (PADDR/PSEL/PENABLE/PWRITE/PWDATA),
// data_out/operation_done/num_of_errors from the ECC block, rsp_* response.
// Option: ECC_SEQ_SHADOW_EN skips NOISE/CODEWORD_WIDTH/DATA_IN writes whose
// value matches the last value written (CTRL is always written).
module ecc_apb_sequencer
    import ecc_seq_pkg::*;
#(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int DATA_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [1:0]                 job_op,
    input  logic [1:0]                 job_width,
    input  logic [DATA_WIDTH-1:0]      job_data,
    input  logic [DATA_WIDTH-1:0]      job_noise,
    output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    output logic [AMBA_WORD-1:0]       PWDATA,
    input  logic [DATA_WIDTH-1:0]      data_out,
    input  logic                       operation_done,
    input  logic [1:0]                 num_of_errors,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_WIDTH-1:0]      rsp_data,
    output logic [1:0]                 rsp_errors,
    output logic                       rsp_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                 state;
    logic [1:0]             idx;
    logic [CNT_W-1:0]       cnt;
    logic [1:0]             op_q;
    logic [1:0]             width_q;
    logic [DATA_WIDTH-1:0]  data_q;
    logic [DATA_WIDTH-1:0]  noise_q;

    logic [1:0]             src_op;
    logic [1:0]             src_width;
    logic [DATA_WIDTH-1:0]  src_data;
    logic [DATA_WIDTH-1:0]  src_noise;
    logic [AMBA_WORD-1:0]   wd [4];
    logic [2:0]             skip;
    logic [1:0]             first_idx;
    logic [1:0]             nxt_idx;
    logic [1:0]             wr_idx;
    logic                   accept;
    logic                   timeout_hit;
    logic                   wm_start;
    logic                   wm_done;
    logic [AMBA_ADDR_WIDTH-1:0] wm_addr;
    logic [AMBA_WORD-1:0]   wm_wdata;

    assign accept      = (state == S_IDLE) && req_valid;
    assign timeout_hit = (state == S_WAIT) && !operation_done
                         && (cnt == CNT_LAST);

    // The first write launches in the acceptance cycle, so it must use the
    // live job inputs; later writes use the latched copy.
    assign src_op    = (state == S_IDLE) ? job_op    : op_q;
    assign src_width = (state == S_IDLE) ? job_width : width_q;
    assign src_data  = (state == S_IDLE) ? job_data  : data_q;
    assign src_noise = (state == S_IDLE) ? job_noise : noise_q;

    assign wd[0] = AMBA_WORD'(src_noise);
    assign wd[1] = AMBA_WORD'(src_width);
    assign wd[2] = AMBA_WORD'(src_data);
    assign wd[3] = AMBA_WORD'(src_op);

`ifdef ECC_SEQ_SHADOW_EN
    logic [AMBA_WORD-1:0] sh_val [3];
    logic [2:0]           sh_vld;

    always_comb begin
        skip = '0;
        for (int i = 0; i < 3; i++)
            skip[i] = sh_vld[i] && (sh_val[i] == wd[i]);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sh_vld <= '0;
            for (int i = 0; i < 3; i++)
                sh_val[i] <= '0;
        end else if (timeout_hit) begin
            sh_vld <= '0;
        end else if (wm_start && wr_idx != 2'd3) begin
            sh_vld[wr_idx] <= 1'b1;
            sh_val[wr_idx] <= wm_wdata;
        end
    end
`else
    assign skip = '0;
`endif

    // Lowest non-skipped slot overall, and after the current one.
    always_comb begin
        first_idx = 2'd3;
        nxt_idx   = 2'd3;
        for (int i = 2; i >= 0; i--) begin
            if (!skip[i])
                first_idx = 2'(i);
            if (!skip[i] && 2'(i) > idx)
                nxt_idx = 2'(i);
        end
    end

    assign wr_idx   = (state == S_IDLE) ? first_idx : nxt_idx;
    assign wm_start = (accept && job_op != OP_RSV)
                      || (state == S_ACCESS && wm_done && idx != 2'd3);
    assign wm_addr  = AMBA_ADDR_WIDTH'(reg_of(wr_idx));
    assign wm_wdata = wd[wr_idx];

    ecc_apb_write_master #(
        .AW (AMBA_ADDR_WIDTH),
        .DW (AMBA_WORD)
    ) u_wm (
        .clk     (clk),
        .rst     (rst),
        .start   (wm_start),
        .addr    (wm_addr),
        .wdata   (wm_wdata),
        .psel    (PSEL),
        .penable (PENABLE),
        .pwrite  (PWRITE),
        .paddr   (PADDR),
        .pwdata  (PWDATA),
        .done    (wm_done)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            req_ready   <= 1'b1;
            idx         <= '0;
            cnt         <= '0;
            op_q        <= '0;
            width_q     <= '0;
            data_q      <= '0;
            noise_q     <= '0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_errors  <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q      <= job_op;
                        width_q   <= job_width;
                        data_q    <= job_data;
                        noise_q   <= job_noise;
                        req_ready <= 1'b0;
                        if (job_op == OP_RSV) begin
                            state       <= S_RESP;
                            rsp_valid   <= 1'b1;
                            rsp_data    <= '0;
                            rsp_errors  <= '0;
                            rsp_timeout <= 1'b1;
                        end else begin
                            state <= S_SETUP;
                            idx   <= first_idx;
                        end
                    end
                end
                S_SETUP: state <= S_ACCESS;
                S_ACCESS: begin
                    if (wm_done) begin
                        if (idx == 2'd3) begin
                            state <= S_WAIT;
                            cnt   <= '0;
                        end else begin
                            state <= S_SETUP;
                            idx   <= nxt_idx;
                        end
                    end
                end
                S_WAIT: begin
                    if (operation_done) begin
                        state       <= S_RESP;
                        rsp_valid   <= 1'b1;
                        rsp_data    <= data_out;
                        rsp_errors  <= num_of_errors;
                        rsp_timeout <= 1'b0;
                    end else if (timeout_hit) begin
                        state       <= S_RESP;
                        rsp_valid   <= 1'b1;
                        rsp_data    <= '0;
                        rsp_errors  <= '0;
                        rsp_timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state     <= S_IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ecc_apb_sequencer.sv
// Directed bench for ecc_apb_sequencer with APB-write and response
// scoreboards; build with ECC_SEQ_SHADOW_EN to exercise the shadow option.
module tb_ecc_apb_sequencer;

    typedef struct packed {
        logic [19:0] a;
        logic [31:0] d;
    } apb_t;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  e;
        logic        t;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  job_op = '0;
    logic [1:0]  job_width = '0;
    logic [31:0] job_data = '0;
    logic [31:0] job_noise = '0;
    logic [19:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] data_out = '0;
    logic        operation_done = 1'b0;
    logic [1:0]  num_of_errors = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_errors;
    logic        rsp_timeout;

    apb_t apb_q[$];
    rsp_t rsp_q[$];
    int   errors = 0;
    int   checks = 0;

    ecc_apb_sequencer #(
        .AMBA_WORD       (32),
        .AMBA_ADDR_WIDTH (20),
        .DATA_WIDTH      (32),
        .TIMEOUT_CYCLES  (64)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .job_op         (job_op),
        .job_width      (job_width),
        .job_data       (job_data),
        .job_noise      (job_noise),
        .PADDR          (PADDR),
        .PSEL           (PSEL),
        .PENABLE        (PENABLE),
        .PWRITE         (PWRITE),
        .PWDATA         (PWDATA),
        .data_out       (data_out),
        .operation_done (operation_done),
        .num_of_errors  (num_of_errors),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_errors     (rsp_errors),
        .rsp_timeout    (rsp_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every APB ACCESS cycle must match the next expected write.
    always @(negedge clk) begin
        apb_t e;
        if (PSEL === 1'b1 && PENABLE === 1'b1) begin
            checks++;
            assert (apb_q.size() != 0) else begin
                errors++;
                $error("FAIL apb_extra: got addr %0h data %0h expected none",
                       PADDR, PWDATA);
            end
            if (apb_q.size() != 0) begin
                e = apb_q.pop_front();
                chk("apb_addr", 64'(PADDR), 64'(e.a));
                chk("apb_data", 64'(PWDATA), 64'(e.d));
                chk("apb_pwrite", 64'(PWRITE), 64'(1));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'(1));
        chk({tag, "_psel"}, 64'(PSEL), 64'(0));
        chk({tag, "_penable"}, 64'(PENABLE), 64'(0));
        chk({tag, "_pwrite"}, 64'(PWRITE), 64'(0));
        chk({tag, "_paddr"}, 64'(PADDR), 64'(0));
        chk({tag, "_pwdata"}, 64'(PWDATA), 64'(0));
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        chk({tag, "_rsp_data"}, 64'(rsp_data), 64'(0));
        chk({tag, "_rsp_errors"}, 64'(rsp_errors), 64'(0));
        chk({tag, "_rsp_timeout"}, 64'(rsp_timeout), 64'(0));
    endtask

    // Drives one request; returns one cycle after the acceptance edge.
    task automatic send_job(input logic [1:0] op, input logic [1:0] w,
                            input logic [31:0] d, input logic [31:0] n,
                            input bit ctrl_only);
        chk("req_ready_idle", 64'(req_ready), 64'(1));
        if (op != 2'd3) begin
            if (!ctrl_only) begin
                apb_q.push_back({20'hC, n});
                apb_q.push_back({20'h8, 30'd0, w});
                apb_q.push_back({20'h4, d});
            end
            apb_q.push_back({20'h0, 30'd0, op});
        end
        job_op    = op;
        job_width = w;
        job_data  = d;
        job_noise = n;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        job_op    = 2'($urandom_range(0, 3));
        job_width = 2'($urandom_range(0, 3));
        job_data  = $urandom;
        job_noise = $urandom;
    endtask

    // Advances to the first WAIT cycle and checks the write-phase length.
    task automatic wait_wait(input string tag, input int exp_n);
        int n = 0;
        while (!(apb_q.size() == 0 && PSEL === 1'b0) && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_wphase_cycles"}, 64'(n), 64'(exp_n));
    endtask

    task automatic do_done(input logic [31:0] d, input logic [1:0] e);
        operation_done = 1'b1;
        data_out       = d;
        num_of_errors  = e;
        tick();
        operation_done = 1'b0;
    endtask

    task automatic finish_rsp(input string tag);
        rsp_t e;
        e = '1;
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(1));
        if (rsp_q.size() != 0)
            e = rsp_q.pop_front();
        chk({tag, "_rsp_data"}, 64'(rsp_data), 64'(e.d));
        chk({tag, "_rsp_errors"}, 64'(rsp_errors), 64'(e.e));
        chk({tag, "_rsp_timeout"}, 64'(rsp_timeout), 64'(e.t));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, "_rsp_dropped"}, 64'(rsp_valid), 64'(0));
        chk({tag, "_req_ready_back"}, 64'(req_ready), 64'(1));
    endtask

    initial begin
        rst = 1'b0;
        tick();
        tick();
        chk_reset("reset");
        rst = 1'b1;
        tick();

        // Encode job, done after 5 WAIT cycles.
        rsp_q.push_back({32'h1E, 2'd0, 1'b0});
        send_job(2'd0, 2'd1, 32'h0000_000E, 32'h20, 1'b0);
        chk("enc_setup_psel", 64'(PSEL), 64'(1));
        chk("enc_setup_penable", 64'(PENABLE), 64'(0));
        chk("enc_setup_paddr", 64'(PADDR), 64'hC);
        chk("enc_setup_req_ready", 64'(req_ready), 64'(0));
        wait_wait("enc", 8);
        repeat (5) tick();
        chk("enc_no_early_rsp", 64'(rsp_valid), 64'(0));
        do_done(32'h1E, 2'd0);
        finish_rsp("enc");

        // Full channel; a stray done during the write phase is ignored.
        rsp_q.push_back({32'h1234_5678, 2'd1, 1'b0});
        send_job(2'd2, 2'd2, 32'hDEAD_BEEF, 32'h0000_0101, 1'b0);
        do_done(32'h0BAD, 2'd3);
        wait_wait("fc", 7);
        do_done(32'h1234_5678, 2'd1);
        data_out      = 32'hFFFF_FFFF;
        num_of_errors = 2'd2;
        for (int i = 0; i < 3; i++) begin
            chk("fc_hold_valid", 64'(rsp_valid), 64'(1));
            chk("fc_hold_data", 64'(rsp_data), 64'h1234_5678);
            chk("fc_hold_errors", 64'(rsp_errors), 64'(1));
            tick();
        end
        finish_rsp("fc");

        // Timeout: response exactly 64 cycles after WAIT entry.
        rsp_q.push_back({32'h0, 2'd0, 1'b1});
        send_job(2'd1, 2'd0, 32'h5, 32'h0, 1'b0);
        wait_wait("to", 8);
        repeat (63) tick();
        chk("to_not_early", 64'(rsp_valid), 64'(0));
        tick();
        finish_rsp("to");

        // Done on the last timeout cycle is a success.
        rsp_q.push_back({32'hA5A5_0001, 2'd2, 1'b0});
        send_job(2'd0, 2'd0, 32'h5, 32'h0, 1'b0);
        wait_wait("edge", 8);
        repeat (63) tick();
        chk("edge_not_early", 64'(rsp_valid), 64'(0));
        do_done(32'hA5A5_0001, 2'd2);
        finish_rsp("edge");

        // Reserved op: no APB, immediate timeout response.
        rsp_q.push_back({32'h0, 2'd0, 1'b1});
        send_job(2'd3, 2'd1, 32'h77, 32'h66, 1'b0);
        chk("rsv_psel", 64'(PSEL), 64'(0));
        finish_rsp("rsv");

        // Reset during the DATA_IN ACCESS cycle.
        send_job(2'd0, 2'd1, 32'h3, 32'h4, 1'b0);
        apb_q.pop_back();
        repeat (5) tick();
        chk("rst_mid_paddr", 64'(PADDR), 64'h4);
        chk("rst_mid_penable", 64'(PENABLE), 64'(1));
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk_reset("rst_mid");
        chk("rst_mid_apb_q", 64'(apb_q.size()), 64'(0));
        tick();
        rsp_q.push_back({32'h0000_0C0C, 2'd0, 1'b0});
        send_job(2'd0, 2'd1, 32'h3, 32'h4, 1'b0);
        chk("restart_paddr", 64'(PADDR), 64'hC);
        wait_wait("restart", 8);
        do_done(32'h0000_0C0C, 2'd0);
        finish_rsp("restart");

        // Two identical jobs back-to-back.
        rsp_q.push_back({32'h0000_1111, 2'd0, 1'b0});
        send_job(2'd0, 2'd2, 32'hCAFE, 32'h11, 1'b0);
        wait_wait("dupa", 8);
        do_done(32'h0000_1111, 2'd0);
        finish_rsp("dupa");
        rsp_q.push_back({32'h0000_2222, 2'd1, 1'b0});
`ifdef ECC_SEQ_SHADOW_EN
        send_job(2'd0, 2'd2, 32'hCAFE, 32'h11, 1'b1);
        chk("dupb_paddr", 64'(PADDR), 64'h0);
        wait_wait("dupb", 2);
`else
        send_job(2'd0, 2'd2, 32'hCAFE, 32'h11, 1'b0);
        chk("dupb_paddr", 64'(PADDR), 64'hC);
        wait_wait("dupb", 8);
`endif
        do_done(32'h0000_2222, 2'd1);
        finish_rsp("dupb");

        tick();
        chk("end_apb_q", 64'(apb_q.size()), 64'(0));
        chk("end_rsp_q", 64'(rsp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
